pipeline_stall_controller: RTL
==============================

# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB). It merges every stall and redirect source into one set of per-register write-enables and bubble-inserts:
- load-use hazard from decode
- data-cache miss in MEM
- instruction-cache miss in IF
- multi-cycle multiply in EX
- taken branch in EX

It replaces the ad-hoc write_PC/write_IFID wiring and holds the only sequential stall state: data-miss wait, multiply countdown and miss watchdog.

## Interface
Parameters:
- MUL_CYCLES, 4, total cycles a multiply occupies EX including its start cycle; legal range 2..15.
- DMISS_TIMEOUT, 1023, DMISS cycles after which the watchdog fires; legal range 1..65535.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_use_hazard  in  1  decode reports a load-use dependency this cycle.
- dmem_miss  in  1  MEM-stage access missed; level, held until fill.
- dmem_ready  in  1  data fill complete; single-cycle pulse.
- imem_miss  in  1  IF fetch missed; level, held by the I-cache until fill.
- ex_mul_start  in  1  instruction in EX is a multi-cycle multiply.
- ex_branch_taken  in  1  EX resolved a taken branch/jump; PC mux selects the target.
- pc_we, ifid_we, idex_we, exmem_we, memwb_we  out  1 each  pipeline register write-enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble (control bits zero) instead of the upstream value; only meaningful with the matching *_we=1.
- ctrl_state  out  2  0=RUN, 1=DMISS, 2=MULT.
- dmiss_timeout  out  1  sticky watchdog error.

## Operation
Outputs are combinational from state and inputs. State and counters are registered.

Default, when nothing is asserted: all *_we=1 and all *_flush=0.

RUN state. The highest-priority active source applies, in this order:
1. dmem_miss
   - pc_we, ifid_we, idex_we, exmem_we = 0.
   - memwb_we=1, memwb_flush=1.
   - Next state DMISS; watchdog counter cleared.
2. ex_mul_start
   - pc_we, ifid_we, idex_we = 0.
   - exmem_we=1, exmem_flush=1; memwb advances.
   - mul_cnt <= MUL_CYCLES-1; next state MULT.
3. ex_branch_taken
   - All *_we=1; ifid_flush=1, idex_flush=1.
   - pc_we=1 even if imem_miss, so the pending fetch is abandoned.
4. load_use_hazard
   - pc_we=0, ifid_we=0; idex_flush=1.
   - Single cycle; stays in RUN.
5. imem_miss
   - pc_we=0; ifid_flush=1; stays in RUN.

DMISS state:
- Frozen pattern of priority 1 is held while dmem_ready=0.
- dmem_ready=1 with ex_mul_start=0: release cycle, all *_we=1, no flush; next state RUN.
- dmem_ready=1 with ex_mul_start=1: the multiply start pattern (priority 2) applies instead; mul_cnt loaded; next state MULT.
- Watchdog counter increments every DMISS cycle, saturating. When it reaches DMISS_TIMEOUT, dmiss_timeout is set and stays set until reset.

MULT state:
- dmem_miss, ex_branch_taken, load_use_hazard and imem_miss are ignored; MEM holds only bubbles.
- mul_cnt>1: the multiply pattern is held; mul_cnt decrements.
- mul_cnt==1: release cycle, all *_we=1, no flush; next state RUN.

Rules:
- ex_mul_start and ex_branch_taken are mutually exclusive by decode. If both are seen, the multiply wins.
- mul_cnt width is 4 bits. Watchdog counter is 16 bits.

## Timing
- Reset, while asserted: state RUN, mul_cnt=0, watchdog=0, dmiss_timeout=0. All *_we=0 and all *_flush=0 are forced; ctrl_state=0.
- Stall response has zero latency: outputs react in the same cycle as the input.
- Multiply: MUL_CYCLES-1 frozen cycles, then 1 release cycle. Total EX occupancy is MUL_CYCLES.
- Data miss: frozen from the dmem_miss cycle through the cycle before dmem_ready. Release happens in the dmem_ready cycle. Minimum one frozen cycle.
- Reset asserted mid-DMISS or mid-MULT aborts immediately to RUN. The in-flight multiply is discarded.

## Configuration
PIPE_STALL_PERF_EN:
- Defined: adds outputs stall_cycles[31:0] and flush_count[31:0], both wrapping and both reset to 0.
  - stall_cycles increments in every cycle with pc_we=0 outside reset.
  - flush_count increments in every cycle with ex_branch_taken honoured.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset, then idle:
  - During reset, all *_we=0.
  - After reset, all *_we=1, flushes 0, ctrl_state=0.
- load_use_hazard for 1 cycle in RUN: pc_we=0, ifid_we=0, idex_flush=1 that cycle only; back to default the next cycle.
- MUL_CYCLES=4, ex_mul_start pulse:
  - pc_we=0 for 3 cycles, with exmem_flush=1 in each.
  - 4th cycle all *_we=1; ctrl_state sequence 0,2,2,2 then 0.
- dmem_miss held 5 cycles, dmem_ready on the 6th:
  - exmem_we=0 and memwb_flush=1 for 5 cycles.
  - Release on the 6th; dmiss_timeout stays 0.
- dmem_miss with ex_branch_taken and load_use_hazard in the same cycle: the data-miss freeze wins; ifid_flush=0, idex_flush=0.
- DMISS_TIMEOUT=8, dmem_ready withheld 20 cycles:
  - dmiss_timeout rises after 8 DMISS cycles.
  - It stays 1 after dmem_ready and clears only on reset.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline: merges hazard, miss, multiply and branch sources.
// Optional performance counters are enabled by defining PIPE_STALL_PERF_EN.
module pipeline_stall_controller #(
    parameter int unsigned MUL_CYCLES    = 4,
    parameter int unsigned DMISS_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_use_hazard,
    input  logic       dmem_miss,
    input  logic       dmem_ready,
    input  logic       imem_miss,
    input  logic       ex_mul_start,
    input  logic       ex_branch_taken,
    output logic       pc_we,
    output logic       ifid_we,
    output logic       idex_we,
    output logic       exmem_we,
    output logic       memwb_we,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       memwb_flush,
    output logic [1:0] ctrl_state,
    output logic       dmiss_timeout
`ifdef PIPE_STALL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DMISS = 2'd1,
        ST_MULT  = 2'd2
    } state_t;

    localparam logic [3:0]  MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [15:0] WD_LIMIT = 16'(DMISS_TIMEOUT);

    state_t      state_reg, state_next;
    logic [3:0]  mul_cnt_reg, mul_cnt_next;
    logic [15:0] wd_reg, wd_next;
    logic        timeout_reg, timeout_next;

    // Decoded action for this cycle; exactly one (or none) is active.
    logic freeze_dmiss, freeze_mul, do_branch, do_lu, do_imiss;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_RUN;
            mul_cnt_reg <= 4'd0;
            wd_reg      <= 16'd0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mul_cnt_reg <= mul_cnt_next;
            wd_reg      <= wd_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        mul_cnt_next = mul_cnt_reg;
        wd_next      = wd_reg;
        timeout_next = timeout_reg;
        freeze_dmiss = 1'b0;
        freeze_mul   = 1'b0;
        do_branch    = 1'b0;
        do_lu        = 1'b0;
        do_imiss     = 1'b0;

        case (state_reg)
            ST_RUN: begin
                if (dmem_miss) begin
                    freeze_dmiss = 1'b1;
                    wd_next      = 16'd0;
                    state_next   = ST_DMISS;
                end else if (ex_mul_start) begin
                    freeze_mul   = 1'b1;
                    mul_cnt_next = MUL_LOAD;
                    state_next   = ST_MULT;
                end else if (ex_branch_taken) begin
                    do_branch = 1'b1;
                end else if (load_use_hazard) begin
                    do_lu = 1'b1;
                end else if (imem_miss) begin
                    do_imiss = 1'b1;
                end
            end
            ST_DMISS: begin
                if (wd_reg != 16'hFFFF) begin
                    wd_next = wd_reg + 16'd1;
                end
                if (wd_next >= WD_LIMIT) begin
                    timeout_next = 1'b1;
                end
                if (dmem_ready) begin
                    // The fill cycle can double as the start of a multiply waiting in EX.
                    if (ex_mul_start) begin
                        freeze_mul   = 1'b1;
                        mul_cnt_next = MUL_LOAD;
                        state_next   = ST_MULT;
                    end else begin
                        state_next = ST_RUN;
                    end
                end else begin
                    freeze_dmiss = 1'b1;
                end
            end
            ST_MULT: begin
                if (mul_cnt_reg > 4'd1) begin
                    freeze_mul   = 1'b1;
                    mul_cnt_next = mul_cnt_reg - 4'd1;
                end else begin
                    mul_cnt_next = 4'd0;
                    state_next   = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Reset forces every enable and bubble low regardless of state.
    always_comb begin
        pc_we       = ~reset & ~(freeze_dmiss | freeze_mul | do_lu | do_imiss);
        ifid_we     = ~reset & ~(freeze_dmiss | freeze_mul | do_lu);
        idex_we     = ~reset & ~(freeze_dmiss | freeze_mul);
        exmem_we    = ~reset & ~freeze_dmiss;
        memwb_we    = ~reset;
        ifid_flush  = ~reset & (do_branch | do_imiss);
        idex_flush  = ~reset & (do_branch | do_lu);
        exmem_flush = ~reset & freeze_mul;
        memwb_flush = ~reset & freeze_dmiss;
    end

    assign ctrl_state    = state_reg;
    assign dmiss_timeout = timeout_reg;

`ifdef PIPE_STALL_PERF_EN
    logic [31:0] stall_cycles_reg;
    logic [31:0] flush_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_reg <= 32'd0;
            flush_count_reg  <= 32'd0;
        end else begin
            if (!pc_we) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
            if (do_branch) begin
                flush_count_reg <= flush_count_reg + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;
`endif

endmodule
